rcvr_fifo: RTL and testbench
============================

// Module: rcvr_fifo
// PURPOSE
//  Parametrised serial frame receiver: hunts a HDR_W-bit header on a 1-bit serial input,
//  then captures a DAT_W-bit body into a FIFO_DEPTH-word output FIFO, read with a
//  ready/reading handshake. Next generation of the fixed 8-bit header/body receiver.
//  Adds generic widths, overlap-correct header detection, output buffering and an
//  optional parity check. Sits between the serial line front-end and the word consumer.
// PARAMETERS
//  HDR_W       8      header length in bits (>=2)
//  HEADER      8'hA5  header pattern, HDR_W bits; bit 0 received first
//  DAT_W       8      body length in bits (>=2)
//  FIFO_DEPTH  4      output FIFO depth in words (power of two, >=2)
// PORTS
//  clock     in   1                        rising-edge clock
//  reset_n   in   1                        async active-low reset
//  data_in   in   1                        serial data, sampled every rising edge
//  reading   in   1                        consumer pops head word this cycle
//  ready     out  1                        FIFO not empty; data_out valid
//  overrun   out  1                        sticky: a completed frame was dropped
//  data_out  out  DAT_W                    FIFO head word
//  level     out  $clog2(FIFO_DEPTH+1)     FIFO occupancy
//  parity_err out 1                        1-cycle pulse, bad-parity frame dropped
// BEHAVIOUR
//  Reset (reset_n=0, async): state=HUNT, fill count=0, FIFO empty; ready=0, overrun=0,
//   level=0, parity_err=0, data_out=0.
//  HUNT: hdr_sr <= {data_in, hdr_sr[HDR_W-1:1]}; fill saturates at HDR_W-1.
//   Match when fill==HDR_W-1 and {data_in,hdr_sr[HDR_W-1:1]}==HEADER -> BODY, bit_cnt=0.
//   Sliding window: overlapping/partial prefixes never cause a missed header.
//  BODY: body shifts left, data_in into LSB (body MSB first); bit_cnt++.
//   On bit DAT_W-1: completed word = {body_sr[DAT_W-2:0], data_in}; push request;
//   -> HUNT (or PARITY if macro enabled), fill cleared: next header starts next cycle.
//  Latency: pushed word visible on data_out/ready the cycle after its last body bit.
//  FIFO: pop when reading && ready; reading while empty ignored.
//   Push accepted if level<FIFO_DEPTH, or if full and a pop occurs the same cycle.
//   Push+pop same cycle: level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  overrun: cleared by any reading; else set when a push is refused (full, no pop);
//   the refused (newest) word is discarded; stored words untouched.
//  Reset mid-frame: partial header/body discarded; FIFO contents lost.
//  No header search during BODY; header bits inside the body are data.
// CONFIGURATION
//  RCVR_PARITY_EN defined: one extra bit after the body (state PARITY), even parity
//   over body+parity bit. Good -> push; bad -> no push, parity_err=1 for one cycle,
//   overrun not affected. Then -> HUNT. Frame length HDR_W+DAT_W+1.
//  RCVR_PARITY_EN undefined: no PARITY state, push straight from BODY, parity_err tied 0.
// TESTING (HDR_W=8, HEADER=8'hA5, DAT_W=8, FIFO_DEPTH=4)
//  1 Bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 -> next cycle ready=1, data_out=8'h3C, level=1.
//  2 Prefix 1,0,1 then full header + body 8'hFF -> one frame, data_out=8'hFF.
//  3 Four frames 8'h01..8'h04, no reading -> level=4; fifth (8'h05) -> overrun=1,
//    data_out=8'h01; pulse reading -> overrun=0, level=3, data_out=8'h02.
//  4 FIFO full, reading asserted in 5th frame's completion cycle -> overrun=0, level=4,
//    tail word 8'h05.
//  5 reset_n low mid-body -> ready=0, level=0 immediately; next full frame 8'h5A
//    received correctly.
//  6 RCVR_PARITY_EN: body 8'h3C, parity 1 -> parity_err pulse, level 0; parity 0 ->
//    data_out=8'h3C.

Source files
------------

// File: rtl/rcvr_fifo.sv
// rcvr_fifo: serial frame receiver with an output word FIFO.
//  Hunts an HDR_W-bit header (bit 0 first) with a sliding window, captures a
//  DAT_W-bit body (MSB first) and pushes it into a FIFO_DEPTH-word FIFO that the
//  consumer drains with the reading/ready handshake.
//  Optional feature macro: RCVR_PARITY_EN adds an even-parity bit after the body;
//  frames with bad parity are dropped and flagged on parity_err for one cycle.
module rcvr_fifo #(
    parameter int               HDR_W      = 8,
    parameter logic [HDR_W-1:0] HEADER     = 8'hA5,
    parameter int               DAT_W      = 8,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             data_in,
    input  logic                             reading,
    output logic                             ready,
    output logic                             overrun,
    output logic [DAT_W-1:0]                 data_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             parity_err
);

    localparam int FILL_W = $clog2(HDR_W);
    localparam int CNT_W  = $clog2(DAT_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH+1);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HDR_W-1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DAT_W-1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

`ifdef RCVR_PARITY_EN
    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_BODY   = 2'd1,
        S_PARITY = 2'd2
    } state_e;
    // The full body word must be held through the parity bit.
    localparam int BODY_W = DAT_W;

    // Odd number of ones across body + parity bit means the frame is corrupt.
    function automatic logic parity_is_odd(input logic [DAT_W:0] bits);
        return ^bits;
    endfunction
`else
    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_BODY = 2'd1
    } state_e;
    // The last body bit comes straight from data_in, so one bit less is stored.
    localparam int BODY_W = DAT_W - 1;
`endif

    // Frame receiver state
    state_e              state_q,   state_d;
    logic [HDR_W-2:0]    hdr_sr_q,  hdr_sr_d;
    logic [FILL_W-1:0]   fill_q,    fill_d;
    logic [BODY_W-1:0]   body_sr_q, body_sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

    // FIFO state
    logic [DAT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]    level_q,   level_d;
    logic                ready_q,   ready_d;
    logic                overrun_q, overrun_d;
    logic [DAT_W-1:0]    data_out_q, data_out_d;

    // Internal strobes
    logic [HDR_W-1:0]    hdr_win_s;
    logic [DAT_W-1:0]    body_word_s;
    logic                push_req_s;
    logic [DAT_W-1:0]    push_word_s;
    logic                pop_s;
    logic                push_ok_s;
    logic [LVL_W-1:0]    remain_s;

`ifdef RCVR_PARITY_EN
    logic                parity_bad_s;
    logic                parity_err_q;
`endif

    // Candidate header window and body word including the bit on the line now.
    assign hdr_win_s   = {data_in, hdr_sr_q};
    assign body_word_s = {body_sr_q[DAT_W-2:0], data_in};

    // Frame FSM: header hunt, body capture, optional parity bit; raises push requests.
    always_comb begin
        state_d     = state_q;
        hdr_sr_d    = hdr_sr_q;
        fill_d      = fill_q;
        body_sr_d   = body_sr_q;
        bit_cnt_d   = bit_cnt_q;
        push_req_s  = 1'b0;
        push_word_s = body_word_s;
`ifdef RCVR_PARITY_EN
        parity_bad_s = 1'b0;
`endif
        case (state_q)
            S_HUNT: begin
                hdr_sr_d = hdr_win_s[HDR_W-1:1];
                if (fill_q == FILL_MAX) begin
                    // Window is full: every cycle is a fresh match attempt, so
                    // overlapping prefixes can never hide a real header.
                    if (hdr_win_s == HEADER) begin
                        state_d   = S_BODY;
                        bit_cnt_d = {CNT_W{1'b0}};
                        fill_d    = {FILL_W{1'b0}};
                    end else begin
                        fill_d    = fill_q;
                    end
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            S_BODY: begin
                body_sr_d = body_word_s[BODY_W-1:0];
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    fill_d    = {FILL_W{1'b0}};
`ifdef RCVR_PARITY_EN
                    state_d    = S_PARITY;
`else
                    state_d    = S_HUNT;
                    push_req_s = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef RCVR_PARITY_EN
            S_PARITY: begin
                state_d     = S_HUNT;
                fill_d      = {FILL_W{1'b0}};
                push_word_s = body_sr_q;
                if (parity_is_odd({body_sr_q, data_in})) begin
                    parity_bad_s = 1'b1;
                end else begin
                    push_req_s   = 1'b1;
                end
            end
`endif
            default: begin
                state_d   = S_HUNT;
                fill_d    = {FILL_W{1'b0}};
                bit_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // FIFO control: pop/push arbitration, occupancy, overrun and next head word.
    always_comb begin
        pop_s     = reading && ready_q;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push_ok_s = push_req_s && ((level_q != LVL_FULL) || pop_s);

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        level_d  = level_q + LVL_W'(push_ok_s) - LVL_W'(pop_s);
        remain_s = level_q - LVL_W'(pop_s);
        ready_d  = (level_d != {LVL_W{1'b0}});

        // Head word is registered; when the FIFO drains to the incoming word it
        // must be taken from the push path because memory is written this edge.
        if (level_d == {LVL_W{1'b0}}) begin
            data_out_d = {DAT_W{1'b0}};
        end else if (remain_s == {LVL_W{1'b0}}) begin
            data_out_d = push_word_s;
        end else begin
            data_out_d = mem_q[rd_ptr_d];
        end

        if (reading) begin
            overrun_d = 1'b0;
        end else if (push_req_s && !push_ok_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Frame receiver and FIFO control registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_HUNT;
            hdr_sr_q   <= {(HDR_W-1){1'b0}};
            fill_q     <= {FILL_W{1'b0}};
            body_sr_q  <= {BODY_W{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= {DAT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            hdr_sr_q   <= hdr_sr_d;
            fill_q     <= fill_d;
            body_sr_q  <= body_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

`ifdef RCVR_PARITY_EN
    // One-cycle flag for a frame dropped on bad parity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_bad_s;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign ready    = ready_q;
    assign overrun  = overrun_q;
    assign data_out = data_out_q;
    assign level    = level_q;

endmodule

// File: tb/tb_rcvr_fifo.sv
// Self-checking bench for rcvr_fifo (HDR_W=8, HEADER=8'hA5, DAT_W=8, FIFO_DEPTH=4).
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rcvr_fifo;

    localparam int         HDR_W = 8;
    localparam int         DAT_W = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] HDR   = 8'hA5;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       data_in = 1'b0;
    logic       reading = 1'b0;
    logic       ready;
    logic       overrun;
    logic       parity_err;
    logic [7:0] data_out;
    logic [2:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit         m_hist[$];     // bits seen while hunting, oldest first
    int         m_phase = 0;   // 0 hunt, 1 body, 2 parity
    logic [7:0] m_body  = 8'h00;
    int         m_nbits = 0;
    logic [7:0] m_q[$];        // FIFO contents, head at index 0
    bit         m_ovr   = 1'b0;
    bit         m_perr  = 1'b0;

    rcvr_fifo #(
        .HDR_W(HDR_W), .HEADER(HDR), .DAT_W(DAT_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .reading(reading),
        .ready(ready), .overrun(overrun), .data_out(data_out), .level(level),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        m_hist.delete();
        m_q.delete();
        m_phase = 0;
        m_body  = 8'h00;
        m_nbits = 0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // Drive one serial bit and the reading strobe, advance the model, cross one edge.
    task automatic step(input logic d, input logic rd);
        logic [7:0] w;
        logic [7:0] val;
        bit         push;
        data_in = d;
        reading = rd;
        push    = 1'b0;
        w       = 8'h00;
        m_perr  = 1'b0;
        if (m_phase == 0) begin
            m_hist.push_back(d);
            if (m_hist.size() > HDR_W) void'(m_hist.pop_front());
            if (m_hist.size() == HDR_W) begin
                for (int i = 0; i < HDR_W; i++) val[i] = m_hist[i];
                if (val == HDR) begin
                    m_phase = 1;
                    m_body  = 8'h00;
                    m_nbits = 0;
                    m_hist.delete();
                end
            end
        end else if (m_phase == 1) begin
            m_body  = 8'((int'(m_body) * 2) + int'(d));
            m_nbits = m_nbits + 1;
            if (m_nbits == DAT_W) begin
`ifdef RCVR_PARITY_EN
                m_phase = 2;
`else
                m_phase = 0;
                push    = 1'b1;
                w       = m_body;
`endif
            end
        end else begin
            m_phase = 0;
            if ((($countones(m_body) + int'(d)) % 2) == 0) begin
                push = 1'b1;
                w    = m_body;
            end else begin
                m_perr = 1'b1;
            end
        end
        if (rd) m_ovr = 1'b0;
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else if (!rd) m_ovr = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    // Header then body (MSB first), plus a correct parity bit when enabled.
    task automatic send_frame(input logic [7:0] w, input logic rd_last);
        for (int i = 0; i < HDR_W; i++) step(HDR[i], 1'b0);
`ifdef RCVR_PARITY_EN
        for (int i = DAT_W - 1; i >= 0; i--) step(w[i], 1'b0);
        step(^w, rd_last);
`else
        for (int i = DAT_W - 1; i >= 0; i--) step(w[i], (i == 0) ? rd_last : 1'b0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (m_q.size() > 0) step(1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        model_clear();
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] body;
        body = 8'h3C;
        for (int i = 0; i < HDR_W; i++) step(HDR[i], 1'b0);
        for (int i = DAT_W - 1; i >= 0; i--) step(body[i], 1'b0);
`ifdef RCVR_PARITY_EN
        step(1'b0, 1'b0);
`endif
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b expected 1", ready); end
        n_cmp++; if (data_out !== 8'h3C) begin n_bad++; $display("FAIL basic_data: got %h expected 3c", data_out); end
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL basic_level: got %0d expected 1", level); end
        drain();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %b expected 0", ready); end
    endtask

    task automatic test_prefix();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        send_frame(8'hFF, 1'b0);
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL prefix_level: got %0d expected 1", level); end
        n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL prefix_data: got %h expected ff", data_out); end
        drain();
    endtask

    task automatic test_overrun();
        for (int f = 1; f <= 4; f++) send_frame(8'(f), 1'b0);
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovr_full_level: got %0d expected 4", level); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        send_frame(8'h05, 1'b0);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        n_cmp++; if (data_out !== 8'h01) begin n_bad++; $display("FAIL ovr_head: got %h expected 01", data_out); end
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovr_level: got %0d expected 4", level); end
        step(1'b0, 1'b1);
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL ovr_pop_level: got %0d expected 3", level); end
        n_cmp++; if (data_out !== 8'h02) begin n_bad++; $display("FAIL ovr_pop_head: got %h expected 02", data_out); end
        drain();
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_words [4];
        exp_words = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int f = 1; f <= 4; f++) send_frame(8'(f), 1'b0);
        send_frame(8'h05, 1'b1);
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL fullpop_overrun: got %b expected 0", overrun); end
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fullpop_level: got %0d expected 4", level); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (data_out !== exp_words[i]) begin
                n_bad++; $display("FAIL fullpop_word%0d: got %h expected %h", i, data_out, exp_words[i]);
            end
            step(1'b0, 1'b1);
        end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL fullpop_empty: got %b expected 0", ready); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h11, 1'b0);
        for (int i = 0; i < HDR_W; i++) step(HDR[i], 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d expected 0", level); end
        model_clear();
        @(posedge clock); #1;
        reset_n = 1'b1;
        send_frame(8'h5A, 1'b0);
        n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL rstmid_data: got %h expected 5a", data_out); end
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL rstmid_after_level: got %0d expected 1", level); end
        drain();
    endtask

`ifdef RCVR_PARITY_EN
    task automatic test_parity();
        logic [7:0] body;
        body = 8'h3C;
        for (int i = 0; i < HDR_W; i++) step(HDR[i], 1'b0);
        for (int i = DAT_W - 1; i >= 0; i--) step(body[i], 1'b0);
        step(1'b1, 1'b0);
        n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: got %b expected 1", parity_err); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL par_bad_level: got %0d expected 0", level); end
        step(1'b0, 1'b0);
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_pulse_end: got %b expected 0", parity_err); end
        for (int i = 0; i < HDR_W; i++) step(HDR[i], 1'b0);
        for (int i = DAT_W - 1; i >= 0; i--) step(body[i], 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (data_out !== 8'h3C) begin n_bad++; $display("FAIL par_good_data: got %h expected 3c", data_out); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_good_flag: got %b expected 0", parity_err); end
        drain();
    endtask
`endif

    task automatic test_random();
        bit         bits[$];
        int         cyc;
        int         rd_pct;
        int         k;
        logic [7:0] w;
        cyc = 0;
        while (cyc < 3000) begin
            bits.delete();
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 6);
                for (int i = 0; i < k; i++) bits.push_back(1'($urandom_range(0, 1)));
            end else begin
                k = $urandom_range(0, 7);
                for (int i = 0; i < k; i++) bits.push_back(HDR[i]);
                for (int i = 0; i < HDR_W; i++) bits.push_back(HDR[i]);
                w = 8'($urandom);
                for (int i = DAT_W - 1; i >= 0; i--) bits.push_back(w[i]);
`ifdef RCVR_PARITY_EN
                bits.push_back((^w) ^ ($urandom_range(0, 3) == 0));
`endif
            end
            rd_pct = (cyc < 1500) ? 15 : 60;
            foreach (bits[i]) begin
                step(bits[i], 1'($urandom_range(0, 99) < rd_pct));
                cyc++;
                n_cmp++;
                if (ready !== (m_q.size() > 0)) begin
                    n_bad++; $display("FAIL rnd_ready @%0d: got %b expected %b", cyc, ready, m_q.size() > 0);
                end
                n_cmp++;
                if (level !== 3'(m_q.size())) begin
                    n_bad++; $display("FAIL rnd_level @%0d: got %0d expected %0d", cyc, level, m_q.size());
                end
                n_cmp++;
                if (overrun !== m_ovr) begin
                    n_bad++; $display("FAIL rnd_overrun @%0d: got %b expected %b", cyc, overrun, m_ovr);
                end
                n_cmp++;
                if (parity_err !== m_perr) begin
                    n_bad++; $display("FAIL rnd_parity_err @%0d: got %b expected %b", cyc, parity_err, m_perr);
                end
                if (m_q.size() > 0) begin
                    n_cmp++;
                    if (data_out !== m_q[0]) begin
                        n_bad++; $display("FAIL rnd_data @%0d: got %h expected %h", cyc, data_out, m_q[0]);
                    end
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_overrun();
        test_full_pop();
        test_reset_mid();
`ifdef RCVR_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
